// File: rtl/stopwatch_pkg.sv
// Shared segment types, constants and the BCD-to-7-segment decode used by the display path.
// Segment bit order is {g,f,e,d,c,b,a}; a 1 lights the segment before any board polarity inversion.
package stopwatch_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b0000000;
    localparam seg_t SEG_DASH  = 7'b1000000;

    // Non-BCD codes 10..15 show a dash so a corrupted count is visible rather than silently dark.
    function automatic seg_t bcd_to_seg_f(input logic [3:0] bcd);
        seg_t seg;
        case (bcd)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Display bus between the BCD count source and the scanner: count/enable in, segment/anode drive out.
// master = count source side, slave = scanner side.
interface seven_seg_scanner_if #(
    parameter int NUM_DIGITS = 2
);
    import stopwatch_pkg::*;

    logic                    enable;
    logic [4*NUM_DIGITS-1:0] number;
    seg_t                    seg;
    logic [NUM_DIGITS-1:0]   an;
    logic                    frame_done;

    modport master (output enable, number, input seg, an, frame_done);
    modport slave  (input enable, number, output seg, an, frame_done);

endinterface

// File: rtl/bcd_to_seg.sv
// Purely combinational single-digit decoder; thin wrapper so the decode sits in its own hierarchy level.
module bcd_to_seg
    import stopwatch_pkg::*;
(
    input  logic [3:0] bcd,
    output seg_t       seg
);

    assign seg = bcd_to_seg_f(bcd);

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 7-segment scanner with a one-cycle blanking gap at the start of every digit slot.
// Optional build macro LEADING_ZERO_BLANK_EN turns on leading-zero blanking.
module seven_seg_scanner
    import stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS     = 2,
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    seven_seg_scanner_if.slave   bus
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [SW-1:0]           slot_cnt;
    logic [DW-1:0]           digit;
    logic [4*NUM_DIGITS-1:0] frame;

    logic slot_last, digit_last, display, digit_blank;
    logic [3:0]            cur_bcd;
    seg_t                  dec_seg, seg_raw;
    logic [NUM_DIGITS-1:0] an_raw;

    assign slot_last  = (slot_cnt == SW'(SCAN_DIV - 1));
    assign digit_last = (digit == DW'(NUM_DIGITS - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt <= '0;
            digit    <= '0;
            frame    <= '0;
        end else if (!bus.enable) begin
            slot_cnt <= '0;
            digit    <= '0;
        end else begin
            // Snapshot only in digit 0's gap so a whole frame shows one coherent value.
            if (slot_cnt == '0 && digit == '0)
                frame <= bus.number;
            if (slot_last) begin
                slot_cnt <= '0;
                digit    <= digit_last ? '0 : digit + DW'(1);
            end else begin
                slot_cnt <= slot_cnt + SW'(1);
            end
        end
    end

    assign cur_bcd = frame[4*digit +: 4];

    bcd_to_seg u_dec (
        .bcd (cur_bcd),
        .seg (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz_blank;

    // Walk down from the top digit; a digit is blanked while everything from it upward is zero.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lz_blank   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above  = zero_above & (frame[4*i +: 4] == 4'd0);
            lz_blank[i] = zero_above & (i != 0);
        end
    end

    assign digit_blank = lz_blank[digit];
`else
    assign digit_blank = 1'b0;
`endif

    // Async reset zeroes slot_cnt, so the outputs go dark the moment rst rises.
    assign display = bus.enable & (slot_cnt != '0) & ~digit_blank;
    assign seg_raw = display ? dec_seg : SEG_BLANK;
    assign an_raw  = display ? (NUM_DIGITS'(1) << digit) : '0;

    assign bus.seg        = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    assign bus.an         = SEG_ACTIVE_LOW ? ~an_raw  : an_raw;
    assign bus.frame_done = bus.enable & slot_last & digit_last;

endmodule
